// File: rtl/carfield_reg_demux_to.sv
// carfield_reg_demux_to: address-decoded reg-bus demux with per-access timeout and slave quarantine
module carfield_reg_demux_to #(
  parameter int unsigned NumSlv        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                mst_valid_i,
  input  logic                                mst_write_i,
  input  logic [AddrWidth-1:0]                mst_addr_i,
  input  logic [DataWidth-1:0]                mst_wdata_i,
  input  logic [DataWidth/8-1:0]              mst_wstrb_i,
  output logic                                mst_ready_o,
  output logic [DataWidth-1:0]                mst_rdata_o,
  output logic                                mst_error_o,
  input  logic [NumSlv-1:0][AddrWidth-1:0]    rule_start_i,
  input  logic [NumSlv-1:0][AddrWidth-1:0]    rule_end_i,
  output logic [NumSlv-1:0]                   slv_valid_o,
  output logic                                slv_write_o,
  output logic [AddrWidth-1:0]                slv_addr_o,
  output logic [DataWidth-1:0]                slv_wdata_o,
  output logic [DataWidth/8-1:0]              slv_wstrb_o,
  input  logic [NumSlv-1:0]                   slv_ready_i,
  input  logic [NumSlv-1:0][DataWidth-1:0]    slv_rdata_i,
  input  logic [NumSlv-1:0]                   slv_error_i,
  input  logic [NumSlv-1:0]                   clr_quarantine_i,
  output logic [NumSlv-1:0]                   quarantine_o,
  output logic [15:0]                         timeout_cnt_o,
  output logic                                busy_o
);
  localparam int unsigned SW = NumSlv > 1 ? $clog2(NumSlv) : 1;
  localparam int unsigned CW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  localparam bit TO_EN = TimeoutCycles > 0;
  typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;
  state_e state, state_n;
  logic [SW-1:0] sel, sel_n, idx;
  logic [CW-1:0] cnt;
  logic hit, blocked, done, tmo, accept;
  logic [NumSlv-1:0] qset;
  // descending scan so the lowest matching rule is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = int'(NumSlv) - 1; k >= 0; k--)
      if (mst_addr_i >= rule_start_i[k] && mst_addr_i < rule_end_i[k]) begin
        hit = 1'b1;
        idx = SW'(k);
      end
  end
  always_comb begin
    accept  = state == IDLE && mst_valid_i;
    blocked = !hit || quarantine_o[idx];
    done    = slv_ready_i[sel];
    tmo     = TO_EN && !done && cnt == LAST;
    state_n = state;
    sel_n   = accept ? idx : sel;
    qset    = '0;
    if (accept) state_n = blocked ? RESP : FWD;
    else if (state == FWD && (done || tmo)) begin
      state_n = RESP;
      qset    = tmo ? NumSlv'(1) << sel : '0;
    end else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel           <= '0;
      cnt           <= '0;
      mst_ready_o   <= 1'b0;
      mst_error_o   <= 1'b0;
      mst_rdata_o   <= '0;
      busy_o        <= 1'b0;
      slv_valid_o   <= '0;
      slv_write_o   <= 1'b0;
      slv_addr_o    <= '0;
      slv_wdata_o   <= '0;
      slv_wstrb_o   <= '0;
      quarantine_o  <= '0;
      timeout_cnt_o <= '0;
    end else begin
      sel          <= sel_n;
      mst_ready_o  <= state_n == RESP;
      busy_o       <= state_n != IDLE;
      slv_valid_o  <= state_n == FWD ? NumSlv'(1) << sel_n : '0;
      quarantine_o <= (quarantine_o & ~clr_quarantine_i) | qset;
      // preload the error response; a forwarded access overwrites it on ready
      if (accept) begin
        slv_write_o <= mst_write_i;
        slv_addr_o  <= mst_addr_i;
        slv_wdata_o <= mst_wdata_i;
        slv_wstrb_o <= mst_wstrb_i;
        cnt         <= '0;
        mst_rdata_o <= '0;
        mst_error_o <= 1'b1;
      end
      if (state == FWD) begin
        cnt <= cnt + 1'b1;
        if (done) begin
          mst_rdata_o <= slv_rdata_i[sel];
          mst_error_o <= slv_error_i[sel];
        end else if (tmo && timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 16'd1;
      end
    end
  end
endmodule

// File: doc/carfield_reg_demux_to.md
# carfield_reg_demux_to

Register-bus demultiplexer with per-transaction timeout and slave quarantine, placed between the Cheshire external reg port and the growing set of Carfield peripheral config slaves (HyperBus PHYs, future domains). It generalises the current single-slave point-to-point config link to `NumSlv` address-decoded slaves. A hung slave returns an error to the master instead of stalling it. Timed-out slaves are fenced off until software clears them.

## Interface
- `NumSlv`, 4: number of downstream reg slaves (1..16).
- `AddrWidth`, 48: request address width.
- `DataWidth`, 32: data width; `wstrb` is `DataWidth/8`.
- `TimeoutCycles`, 256: maximum cycles `slv_valid_o` is held per access. 0 disables the timeout.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `mst_valid_i`  in  1  request valid, held until `mst_ready_o`.
- `mst_write_i`  in  1  1 = write.
- `mst_addr_i`  in  AddrWidth  request address.
- `mst_wdata_i`  in  DataWidth  write data.
- `mst_wstrb_i`  in  DataWidth/8  byte strobes.
- `mst_ready_o`  out  1  one-cycle completion pulse.
- `mst_rdata_o`  out  DataWidth  read data, valid with `mst_ready_o`.
- `mst_error_o`  out  1  error flag, valid with `mst_ready_o`.
- `rule_start_i`  in  NumSlv×AddrWidth  inclusive start address per slave; quasi-static.
- `rule_end_i`  in  NumSlv×AddrWidth  exclusive end address per slave; quasi-static.
- `slv_valid_o`  out  NumSlv  one-hot request valid.
- `slv_write_o`, `slv_addr_o`, `slv_wdata_o`, `slv_wstrb_o`  out  1/AddrWidth/DataWidth/DataWidth/8  registered request fields, broadcast to all slaves.
- `slv_ready_i`  in  NumSlv  slave completion.
- `slv_rdata_i`  in  NumSlv×DataWidth  slave read data.
- `slv_error_i`  in  NumSlv  slave error.
- `clr_quarantine_i`  in  NumSlv  one-cycle pulse; clears the matching quarantine bit.
- `quarantine_o`  out  NumSlv  sticky per-slave timeout flag.
- `timeout_cnt_o`  out  16  total timeouts, saturating.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- **FSM states:** IDLE, FWD, RESP.
- **IDLE:** `mst_valid_i` is sampled only in this state.
  - Decode is `start ≤ addr < end`. If rules overlap, the lowest index wins.
  - On any request, latch `write`, `addr`, `wdata`, `wstrb` and the select index.
  - Hit on a non-quarantined slave: go to FWD and clear the wait counter.
  - Decode miss or quarantined slave: go to RESP with `error=1`, `rdata=0`.
- **FWD:**
  - `slv_valid_o[sel]=1`, driven from the registered request.
  - If `slv_ready_i[sel]=1`, capture `slv_rdata_i[sel]` and `slv_error_i[sel]`, then go to RESP.
  - Otherwise increment the wait counter.
  - If the counter equals `TimeoutCycles-1` with no ready (and timeout is enabled):
    - go to RESP with `error=1`, `rdata=0`;
    - set `quarantine_o[sel]`;
    - increment `timeout_cnt_o`, saturating at 0xFFFF.
  - Ready on the final allowed cycle is a normal completion, not a timeout.
  - `slv_ready_i` on non-selected slaves is ignored.
- **RESP:** `mst_ready_o=1` for exactly one cycle, with registered rdata/error. Next state is IDLE.
- **Quarantine update:** `clr_quarantine_i[k]` clears bit k. If a clear and a set hit the same bit in the same cycle, set wins.
- **Master protocol violation:** `mst_valid_i` dropping mid-transaction is ignored; the access completes and `mst_ready_o` still pulses.
- **Width rules:**
  - Wait counter width is `$clog2(TimeoutCycles+1)`.
  - The select index is `$clog2(NumSlv)` bits, minimum 1.
  - `timeout_cnt_o` never wraps.

## Timing
- **Reset values (synchronous, on the edge `rst_i=1`):**
  - state IDLE;
  - `mst_ready_o`, `mst_error_o`, `busy_o`, `slv_valid_o` all 0;
  - `mst_rdata_o` and all `slv_*` fields 0;
  - `quarantine_o=0`, `timeout_cnt_o=0`.
- **Reset mid-access:** the access is abandoned with no master response. `slv_valid_o` is 0 from the cycle after the reset edge.
- **Hit latency:** valid sampled at cycle 0; `slv_valid_o` in cycles 1..k; `mst_ready_o` at cycle k+1. Minimum is ready at cycle 2.
- **Miss or quarantined latency:** `mst_ready_o` at cycle 1.
- **Timeout:** `slv_valid_o` is high for exactly `TimeoutCycles` cycles; `mst_ready_o` follows on the next cycle.
- **Back-to-back:** a new request can be accepted in the IDLE cycle right after RESP, so throughput is one access per 3 cycles.
- **Outputs:** all outputs are registered; there is no combinational master→slave path.

## Test plan
- Write 0xCAFEF00D, strobe 0xF, to an address in rule 2. Slave 2 readies in its first valid cycle. Expect `slv_valid_o=4'b0100` for 1 cycle, `mst_ready_o` at cycle 2, `error=0`.
- Read from an unmapped address. Expect `mst_ready_o` at cycle 1, `error=1`, `rdata=0`, and no `slv_valid_o` activity.
- With `TimeoutCycles=8`, slave 1 never readies. Expect `slv_valid_o[1]` high for 8 cycles, error response, `quarantine_o=4'b0010`, `timeout_cnt_o=1`. A repeat access to slave 1 errors at cycle 1.
- Slave readies on exactly the 8th valid cycle. Expect a normal completion, no quarantine, counter unchanged.
- Pulse `clr_quarantine_i[1]` in the same cycle as a new timeout on slave 1. Expect the bit to stay set. Clear it alone, then access slave 1 and see it forwarded.
- Overlapping rules 0 and 3: expect slave 0 selected. Assert `rst_i` mid-FWD: expect `slv_valid_o=0` next cycle and all outputs at reset values.
